// File: rtl/uart_pkg.sv
// Shared UART package: default word width and FIFO depth, which the receiver,
// transmitter and FIFO wrappers all use.
package uart_pkg;

   localparam int UART_W_OUT         = 16;
   localparam int UART_RX_FIFO_DEPTH = 16;

   typedef logic [UART_W_OUT-1:0] uart_word_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// FIFO storage array with a synchronous write port and an asynchronous read port.
// The array is deliberately not reset; the control logic decides which entries are valid.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int W_OUT = UART_W_OUT,
   parameter int DEPTH = UART_RX_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [W_OUT-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [W_OUT-1:0] rdata
);

   logic [W_OUT-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer: captures receiver words without backpressure,
// drops them when full (sticky overflow) and serves them on a valid/ready port.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int W_OUT = UART_W_OUT,
   parameter int DEPTH = UART_RX_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     s_valid,
   input  logic [W_OUT-1:0]         s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [W_OUT-1:0]         m_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             pop, push, drop;
   logic [W_OUT-1:0] rdData;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   always_comb begin
      pop  = (count_q != '0) && m_ready;
      push = s_valid && ((count_q != FULL_COUNT) || pop);
      drop = s_valid && !push;

      wrPtr_d    = push ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_d    = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   uart_fifo_mem #(
      .W_OUT (W_OUT),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wrPtr_q),
      .wdata (s_data),
      .raddr (rdPtr_q),
      .rdata (rdData)
   );

   assign m_valid  = (count_q != '0);
   assign m_data   = m_valid ? rdData : '0;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model of the buffer.
module tb_uart_rx_fifo;

   localparam int W_OUT = 16;
   localparam int DEPTH = 16;

   logic              clk;
   logic              rstn;
   logic              s_valid;
   logic [W_OUT-1:0]  s_data;
   logic              m_valid;
   logic              m_ready;
   logic [W_OUT-1:0]  m_data;
   logic [4:0]        count;
   logic              overflow;
   logic              clr_overflow;

   int nCompared   = 0;
   int nMismatched = 0;

   logic [W_OUT-1:0] modelQ [$];
   logic             modelOvf = 1'b0;

   uart_rx_fifo #(.W_OUT(W_OUT), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      assert (got === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Compare every output against what the reference queue says should be visible.
   task automatic checkOutput(input string tag);
      logic [W_OUT-1:0] expData;
      expData = (modelQ.size() != 0) ? modelQ[0] : '0;
      checkVal({tag, ".m_valid"},  32'(m_valid),  32'(modelQ.size() != 0));
      checkVal({tag, ".m_data"},   32'(m_data),   32'(expData));
      checkVal({tag, ".count"},    32'(count),    32'(modelQ.size()));
      checkVal({tag, ".overflow"}, 32'(overflow), 32'(modelOvf));
   endtask

   // Drive one cycle of inputs, advance the model by the same rules, then check after the edge.
   task automatic applyStimulus(input string tag, input logic sv, input logic [W_OUT-1:0] data,
                                input logic rdy, input logic clr);
      logic doPop, doPush;
      s_valid      = sv;
      s_data       = data;
      m_ready      = rdy;
      clr_overflow = clr;
      doPop  = (modelQ.size() != 0) && rdy;
      doPush = sv && (modelQ.size() < DEPTH || doPop);
      if (doPop)  void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(data);
      if (sv && !doPush) modelOvf = 1'b1;
      else if (clr)      modelOvf = 1'b0;
      @(posedge clk);
      #1;
      s_valid      = 1'b0;
      m_ready      = 1'b0;
      clr_overflow = 1'b0;
      checkOutput(tag);
   endtask

   initial begin
      rstn         = 1'b0;
      s_valid      = 1'b0;
      s_data       = '0;
      m_ready      = 1'b0;
      clr_overflow = 1'b0;
      #12;
      checkVal("rst.m_valid",  32'(m_valid),  32'd0);
      checkVal("rst.m_data",   32'(m_data),   32'd0);
      checkVal("rst.count",    32'(count),    32'd0);
      checkVal("rst.overflow", 32'(overflow), 32'd0);
      rstn = 1'b1;
      $display("[TB] reset released");

      // Two words buffered, then drained back-to-back.
      applyStimulus("t1.push0", 1'b1, 16'h1234, 1'b0, 1'b0);
      applyStimulus("t1.push1", 1'b1, 16'hABCD, 1'b0, 1'b0);
      checkVal("t1.count2", 32'(count),  32'd2);
      checkVal("t1.head",   32'(m_data), 32'h1234);
      applyStimulus("t1.pop0", 1'b0, 16'h0, 1'b1, 1'b0);
      checkVal("t1.second", 32'(m_data), 32'hABCD);
      applyStimulus("t1.pop1", 1'b0, 16'h0, 1'b1, 1'b0);
      checkVal("t1.empty_valid", 32'(m_valid), 32'd0);
      checkVal("t1.empty_data",  32'(m_data),  32'd0);

      // Fill to capacity and overrun once.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus("t2.fill", 1'b1, 16'(i), 1'b0, 1'b0);
      end
      applyStimulus("t2.drop", 1'b1, 16'hDEAD, 1'b0, 1'b0);
      checkVal("t2.count_full", 32'(count),    32'd16);
      checkVal("t2.ovf_set",    32'(overflow), 32'd1);

      // Clear collides with a drop: set must win; a lone clear then takes effect.
      applyStimulus("t5.clr_drop", 1'b1, 16'hD00D, 1'b0, 1'b1);
      checkVal("t5.ovf_kept", 32'(overflow), 32'd1);
      applyStimulus("t5.clr_only", 1'b0, 16'h0, 1'b0, 1'b1);
      checkVal("t5.ovf_clr", 32'(overflow), 32'd0);

      // Full with a simultaneous pop accepts the new word without overflow.
      applyStimulus("t3.full_pop_push", 1'b1, 16'hBEEF, 1'b1, 1'b0);
      checkVal("t3.count_full", 32'(count),    32'd16);
      checkVal("t3.ovf_zero",   32'(overflow), 32'd0);
      checkVal("t3.next_head",  32'(m_data),   32'h0001);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus("t3.drain", 1'b0, 16'h0, 1'b1, 1'b0);
         if (i == 14) checkVal("t3.beef_last", 32'(m_data), 32'hBEEF);
      end
      checkVal("t3.drained", 32'(m_valid), 32'd0);

      // Streaming: one push and one pop per cycle, pointers wrap repeatedly.
      for (int i = 0; i < 40; i++) begin
         applyStimulus("t4.stream", 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0);
         checkVal("t4.word",  32'(m_data), 32'(16'h0100 + i));
         checkVal("t4.count", 32'(count),  32'd1);
      end
      applyStimulus("t4.final_pop", 1'b0, 16'h0, 1'b1, 1'b0);

      // Asynchronous reset glitch with words stored and overflow set.
      for (int i = 0; i < DEPTH + 1; i++) begin
         applyStimulus("t6.load", 1'b1, 16'($urandom), 1'b0, 1'b0);
      end
      for (int i = 0; i < DEPTH - 5; i++) begin
         applyStimulus("t6.trim", 1'b0, 16'h0, 1'b1, 1'b0);
      end
      checkVal("t6.five", 32'(count), 32'd5);
      #2;
      rstn = 1'b0;
      #1;
      checkVal("t6.rst_valid", 32'(m_valid),  32'd0);
      checkVal("t6.rst_count", 32'(count),    32'd0);
      checkVal("t6.rst_ovf",   32'(overflow), 32'd0);
      checkVal("t6.rst_data",  32'(m_data),   32'd0);
      #1;
      rstn = 1'b1;
      modelQ.delete();
      modelOvf = 1'b0;
      applyStimulus("t6.after", 1'b1, 16'h5555, 1'b0, 1'b0);
      checkVal("t6.data5555", 32'(m_data), 32'h5555);
      checkVal("t6.count1",   32'(count),  32'd1);

      // Randomized traffic, alternating push-heavy and pop-heavy phases.
      for (int i = 0; i < 600; i++) begin
         logic sv, rdy, clr;
         if ((i / 100) % 2 == 0) begin
            sv  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 3);
         end else begin
            sv  = ($urandom_range(0, 9) < 4);
            rdy = ($urandom_range(0, 9) < 8);
         end
         clr = ($urandom_range(0, 19) == 0);
         applyStimulus("rnd", sv, 16'($urandom), rdy, clr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side elastic buffer placed directly downstream of the UART receiver. It captures every `W_OUT`-bit word the receiver emits as a single-cycle `valid` pulse, which carries no backpressure. It stores the words in a `DEPTH`-entry FIFO and presents them to the consuming logic on a valid/ready handshake. Words that arrive while the FIFO is full are dropped, and a sticky overflow flag records the loss.

## Interface
Parameters:
- `W_OUT`, 16, word width; must match the receiver's output word width.
- `DEPTH`, 16, number of FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rstn`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  one-cycle pulse from the receiver: `s_data` holds a new word.
- `s_data`  in  `W_OUT`  received word.
- `m_valid`  out  1  FIFO not empty; `m_data` holds the oldest word.
- `m_ready`  in  1  consumer accepts the word in any cycle where `m_valid && m_ready`.
- `m_data`  out  `W_OUT`  oldest stored word; `'0` while `m_valid` = 0.
- `count`  out  `$clog2(DEPTH)+1`  number of words currently stored, 0…`DEPTH`.
- `overflow`  out  1  sticky: at least one word was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Storage:
  - `DEPTH` registers; the storage itself is not reset.
  - Write pointer `wr_ptr` and read pointer `rd_ptr` are each `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
  - A separate `count` register, not derived from pointer difference, distinguishes full from empty.
- Push:
  - Condition: `s_valid && (count < DEPTH || pop)`.
  - Action: `mem[wr_ptr] <= s_data`, then `wr_ptr++`.
- Pop:
  - Condition: `m_valid && m_ready`.
  - Action: `rd_ptr++`.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop or on neither.
- Full with simultaneous pop: the push is accepted. The freed slot is the one written, and `count` stays at `DEPTH`.
- Empty with `s_valid`: no bypass path. The word becomes visible the next cycle.
- Drop condition: `s_valid && count == DEPTH && !pop`. The word is discarded, and pointers and `count` do not change.
- `overflow` update:
  - Set on any drop cycle.
  - Cleared by `clr_overflow`.
  - If a drop and `clr_overflow` occur in the same cycle, set wins.
- `m_ready` while `m_valid` = 0: ignored; no state change.
- Outputs:
  - `m_valid = (count != 0)`.
  - `m_data = m_valid ? mem[rd_ptr] : '0`.
  - Both are combinational from registers only; no input-to-output combinational path.
- Reset, whether asserted idle or mid-operation, discards all contents immediately (asynchronously). Pointers, `count` and `overflow` go to 0.

## Timing
- Reset values:
  - `m_valid` = 0.
  - `m_data` = 0.
  - `count` = 0.
  - `overflow` = 0.
- Latency: a push at edge N gives `m_valid` = 1 and the word on `m_data` after edge N, so the word is consumable in cycle N+1.
- Pop: consumed at edge N; the next word, or `m_valid` = 0, appears after edge N.
- Throughput: sustains one push and one pop per clock indefinitely.
- `overflow`: asserts the cycle after the dropping edge and stays high until cleared.
- `count`: registered; updates at the same edge as the pointers.
- Reset release: the first push is honoured on the first rising edge with `rstn` = 1.

## Structure
- Shared package `uart_pkg`:
  - `localparam` defaults `UART_W_OUT = 16` and `UART_RX_FIFO_DEPTH = 16`.
  - `typedef logic [UART_W_OUT-1:0] uart_word_t`.
  - The receiver and transmitter wrappers use the same defaults.
- One sub-module, `uart_fifo_mem`:
  - `DEPTH × W_OUT` register array with a synchronous write port and an asynchronous read port.
  - Holds no control logic.
- Top: pointer, count and overflow logic plus output gating.
- Elaboration-time assertion: `DEPTH` is a power of two and ≥ 2.

## Test plan
- Reset, then push `0x1234`, `0xABCD` with `m_ready` = 0 → `count` = 2, `m_data` = `0x1234`. Raise `m_ready` → `0x1234` then `0xABCD` pop on consecutive cycles, then `m_valid` = 0, `m_data` = 0.
- Push 16 words `0x0000`…`0x000F` with `m_ready` = 0, then push `0xDEAD` → `count` stays 16, `overflow` = 1 next cycle. Drain → exactly `0x0000`…`0x000F` in order, with no `0xDEAD`.
- Full (`count` = 16) and `m_ready` = 1 while pushing `0xBEEF` → `count` stays 16, `overflow` stays 0. `0xBEEF` emerges 16th after that pop.
- `m_ready` held 1 while pushing one word per cycle for 40 cycles (`0x0100`+i) → each word emerges exactly one cycle after its push, `count` never exceeds 1. Over the 40 cycles both pointers wrap twice and no word is lost.
- `overflow` = 1, then `clr_overflow` = 1 in the same cycle as a drop → `overflow` stays 1. `clr_overflow` alone the next cycle → `overflow` = 0.
- 5 words stored, `rstn` pulsed low mid-stream for a sub-cycle glitch → `m_valid`, `count`, `overflow` and `m_data` are all 0 immediately. Next push `0x5555` → `m_data` = `0x5555`, `count` = 1.
